multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Sits between the execute stage and the multdiv unit. Decodes a mult/div instruction
//  in X, issues a single-cycle ctrl_MULT/ctrl_DIV pulse, and stalls the pipeline until
//  md_resultRDY. It captures the result, then presents one writeback beat to the
//  regfile: rd/result, or rstatus ($r30) on exception or timeout.
// PARAMETERS
//  TIMEOUT     40  max cycles waited in BUSY before forcing an exception writeback
//  RSTATUS_REG 30  regfile index written on exception
//  EXC_MULT    4   rstatus code written for a mult exception
//  EXC_DIV     5   rstatus code written for a div exception / divide-by-zero
// PORTS
//  clock          in   1   system clock, all state updates on posedge
//  reset          in   1   asynchronous, active-high; clears all state
//  ex_isMult      in   1   X-stage instruction is mul
//  ex_isDiv       in   1   X-stage instruction is div (never both with ex_isMult)
//  ex_rd          in   5   destination register of X-stage instruction
//  ex_operandA    in   32  bypassed operand A
//  ex_operandB    in   32  bypassed operand B
//  md_result      in   32  multdiv data_result
//  md_exception   in   1   multdiv data_exception
//  md_resultRDY   in   1   multdiv data_resultRDY
//  ctrl_MULT      out  1   one-cycle start pulse to multdiv
//  ctrl_DIV       out  1   one-cycle start pulse to multdiv
//  md_operandA    out  32  = ex_operandA (combinational pass-through)
//  md_operandB    out  32  = ex_operandB
//  stall          out  1   freeze PC/F/D/X latches
//  wb_valid       out  1   one-cycle regfile write enable
//  wb_rd          out  5   write address
//  wb_data        out  32  write data
//  busy_rd        out  5   rd of in-flight op (0 when none), for hazard detection
// BEHAVIOUR
//  Reset: state=IDLE; ctrl_*, stall, wb_valid = 0; wb_rd, wb_data, busy_rd, counter = 0.
//  States: IDLE, BUSY, DONE (2-bit register).
//  IDLE: if ex_isMult|ex_isDiv, drive the matching ctrl_* high combinationally this cycle
//    and set stall=1. On posedge: latch op type, ex_rd -> busy_rd, clear counter, go BUSY.
//    Otherwise ctrl_*=0, stall=0, and state holds.
//  BUSY: stall=1, ctrl_*=0, ex_* ignored, counter increments each cycle.
//    md_resultRDY=1: capture md_result/md_exception, go DONE.
//    counter==TIMEOUT-1 with no RDY: force exception capture, go DONE.
//  DONE: stall=0, wb_valid=1 for exactly this cycle, busy_rd cleared on exit, next=IDLE.
//    No exception: wb_rd=latched rd, wb_data=captured result.
//    Exception or timeout: wb_rd=RSTATUS_REG, wb_data=EXC_MULT or EXC_DIV (zero-extended).
//    Latched rd==0 and no exception: wb_valid=0 ($r0 never written).
//    ex_is* seen in DONE is the same instruction leaving X and must not reissue.
//  Back-to-back mult/div: the next op enters X in the cycle after DONE and issues from
//    IDLE; minimum spacing between pulses = latency+2 cycles.
//  md_resultRDY outside BUSY is ignored.
//  Reset mid-operation: return to IDLE immediately; in-flight result is discarded,
//    no wb_valid.
//  wb_* and busy_rd are registered outputs; ctrl_* and stall are decoded from state and ex_*.
// TESTING
//  mul 7*6, rd=3, RDY after 32 cycles -> one ctrl_MULT pulse, stall high 33 cycles,
//    then wb_valid=1, wb_rd=3, wb_data=42.
//  div 100/0, rd=5, md_exception=1 -> wb_rd=30, wb_data=5, one wb_valid beat.
//  mul 0x10000*0x10000 with md_exception=1 -> wb_rd=30, wb_data=4.
//  md_resultRDY never asserted -> after TIMEOUT cycles, wb_rd=30, wb_data=EXC code,
//    stall drops.
//  Two muls back-to-back -> exactly two ctrl_MULT pulses, two wb beats in order,
//    no reissue in DONE.
//  reset pulsed during BUSY -> stall=0 immediately, state IDLE, no wb_valid afterward.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall controller between the execute stage and the multdiv unit: pulses a
// start, freezes the pipeline until the result (or a timeout), then emits one writeback.
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT     = 40,
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned EXC_MULT    = 4,
  parameter int unsigned EXC_DIV     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_isMult,
  input  logic        ex_isDiv,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_operandA,
  input  logic [31:0] ex_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  busy_rd
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic          is_div_q,   is_div_d;
  logic [4:0]    busy_rd_q,  busy_rd_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q,    wb_rd_d;
  logic [31:0]   wb_data_q,  wb_data_d;
  logic          take_exc;

  assign md_operandA = ex_operandA;
  assign md_operandB = ex_operandB;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign busy_rd     = busy_rd_q;

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    busy_rd_d  = busy_rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    stall      = 1'b0;
    take_exc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((ex_isMult || ex_isDiv) && !reset) begin
          ctrl_MULT = ex_isMult;
          ctrl_DIV  = ex_isDiv;
          stall     = 1'b1;
          is_div_d  = ex_isDiv;
          busy_rd_d = ex_rd;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = !reset;
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (md_resultRDY || (cnt_q == CW'(TIMEOUT - 1))) begin
          take_exc = !md_resultRDY || md_exception;
          state_d  = S_DONE;
          if (take_exc) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = 5'(RSTATUS_REG);
            wb_data_d  = is_div_q ? 32'(EXC_DIV) : 32'(EXC_MULT);
          end else begin
            wb_valid_d = (busy_rd_q != '0);
            wb_rd_d    = busy_rd_q;
            wb_data_d  = md_result;
          end
        end
      end
      S_DONE: begin
        // The instruction still visible in X here is the one just completed.
        busy_rd_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      busy_rd_q  <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      busy_rd_q  <= busy_rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: per-operation timeline model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_isMult = 1'b0, ex_isDiv = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_operandA = '0, ex_operandB = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0, md_resultRDY = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_rd, busy_rd;

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(30), .EXC_MULT(4), .EXC_DIV(5)) dut (
    .clock(clock), .reset(reset),
    .ex_isMult(ex_isMult), .ex_isDiv(ex_isDiv), .ex_rd(ex_rd),
    .ex_operandA(ex_operandA), .ex_operandB(ex_operandB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_rd(busy_rd)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected values for the current cycle, set by the stimulus.
  logic        chk_en = 1'b0;
  logic        exp_cm, exp_cd, exp_stall, exp_wbv;
  logic [4:0]  exp_wbrd, exp_busy;
  logic [31:0] exp_wbdata, exp_opa, exp_opb;

  // Event tallies used by the literal checks.
  int stall_cyc, mult_pulses, div_pulses, wb_beats;
  logic [4:0]  last_wbrd;
  logic [31:0] last_wbdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ctrl_MULT", 32'(ctrl_MULT), 32'(exp_cm));
      chk("ctrl_DIV", 32'(ctrl_DIV), 32'(exp_cd));
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      chk("busy_rd", 32'(busy_rd), 32'(exp_busy));
      chk("md_operandA", md_operandA, exp_opa);
      chk("md_operandB", md_operandB, exp_opb);
      if (exp_wbv) begin
        chk("wb_rd", 32'(wb_rd), 32'(exp_wbrd));
        chk("wb_data", wb_data, exp_wbdata);
      end
    end
    if (stall) stall_cyc++;
    if (ctrl_MULT) mult_pulses++;
    if (ctrl_DIV) div_pulses++;
    if (wb_valid) begin
      wb_beats++;
      last_wbrd = wb_rd;
      last_wbdata = wb_data;
    end
  end

  task automatic clear_tallies();
    stall_cyc = 0; mult_pulses = 0; div_pulses = 0; wb_beats = 0;
    last_wbrd = '0; last_wbdata = '0;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) begin
      @(posedge clock); #1;
      ex_isMult = 1'b0; ex_isDiv = 1'b0; ex_rd = 5'(j + 11);
      ex_operandA = 32'h1234_0000 + 32'(j); ex_operandB = ~ex_operandA;
      md_resultRDY = j[0]; md_exception = 1'b1; md_result = 32'hFACE_0000;
      exp_cm = 0; exp_cd = 0; exp_stall = 0; exp_wbv = 0; exp_busy = '0;
      exp_opa = ex_operandA; exp_opb = ex_operandB;
      exp_wbrd = '0; exp_wbdata = '0;
    end
  endtask

  // One instruction from issue to writeback. lat = BUSY cycle (1-based) on which RDY
  // is given; a lat outside 1..TIMEOUT means RDY never arrives.
  task automatic run_op(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic exc,
                        input logic [31:0] res);
    bit to;
    int n;
    to = !(lat >= 1 && lat <= TIMEOUT);
    n  = to ? TIMEOUT : lat;
    for (int j = 0; j <= n + 1; j++) begin
      @(posedge clock); #1;
      ex_isMult = !is_div; ex_isDiv = is_div; ex_rd = rd;
      ex_operandA = a; ex_operandB = b;
      // RDY outside BUSY (issue and writeback cycles) must be ignored.
      md_resultRDY = (j == n && !to) || j == 0 || j == n + 1;
      md_exception = (j == n && !to) ? exc : 1'b1;
      md_result    = (j == n && !to) ? res : 32'hBAD0_0000 + 32'(j);
      exp_cm    = (j == 0) && !is_div;
      exp_cd    = (j == 0) && is_div;
      exp_stall = (j <= n);
      exp_busy  = (j == 0) ? 5'd0 : rd;
      exp_wbv   = (j == n + 1) && (to || exc || rd != 0);
      exp_wbrd  = (to || exc) ? 5'd30 : rd;
      exp_wbdata = (to || exc) ? (is_div ? 32'd5 : 32'd4) : res;
      exp_opa = a; exp_opb = b;
    end
  endtask

  initial begin
    #2;
    chk("reset stall", 32'(stall), 0);
    chk("reset ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    chk("reset wb_valid", 32'(wb_valid), 0);
    chk("reset wb_rd", 32'(wb_rd), 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset busy_rd", 32'(busy_rd), 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle(3);

    // mul 7*6 -> 42, RDY after 32 BUSY cycles
    settle(); clear_tallies();
    run_op(1'b0, 5'd3, 32'd7, 32'd6, 32, 1'b0, 32'd42);
    settle();
    chk("mul stall cycles", 32'(stall_cyc), 33);
    chk("mul pulses", 32'(mult_pulses), 1);
    chk("mul wb beats", 32'(wb_beats), 1);
    chk("mul wb_rd", 32'(last_wbrd), 3);
    chk("mul wb_data", last_wbdata, 42);
    idle(2);

    // div 100/0 with exception
    settle(); clear_tallies();
    run_op(1'b1, 5'd5, 32'd100, 32'd0, 3, 1'b1, 32'hFFFF_FFFF);
    settle();
    chk("div0 wb_rd", 32'(last_wbrd), 30);
    chk("div0 wb_data", last_wbdata, 5);
    chk("div0 wb beats", 32'(wb_beats), 1);
    chk("div0 pulses", 32'(div_pulses), 1);

    // mul overflow exception
    clear_tallies();
    run_op(1'b0, 5'd7, 32'h1_0000, 32'h1_0000, 32, 1'b1, 32'd0);
    settle();
    chk("ovf wb_rd", 32'(last_wbrd), 30);
    chk("ovf wb_data", last_wbdata, 4);

    // timeouts
    clear_tallies();
    run_op(1'b1, 5'd9, 32'd1, 32'd2, 1000, 1'b0, 32'd0);
    settle();
    chk("div timeout stall cycles", 32'(stall_cyc), TIMEOUT + 1);
    chk("div timeout wb_rd", 32'(last_wbrd), 30);
    chk("div timeout wb_data", last_wbdata, 5);
    run_op(1'b0, 5'd2, 32'd3, 32'd4, 0, 1'b0, 32'd0);
    idle(1);

    // RDY on the last allowed cycle beats the timeout
    run_op(1'b0, 5'd12, 32'd5, 32'd5, TIMEOUT, 1'b0, 32'd25);

    // back-to-back muls
    settle(); clear_tallies();
    run_op(1'b0, 5'd4, 32'd1, 32'd11, 2, 1'b0, 32'd11);
    run_op(1'b0, 5'd6, 32'd2, 32'd11, 1, 1'b0, 32'd22);
    settle();
    chk("b2b pulses", 32'(mult_pulses), 2);
    chk("b2b wb beats", 32'(wb_beats), 2);
    chk("b2b last wb_data", last_wbdata, 22);

    // rd==0: suppressed without exception, rstatus with exception
    clear_tallies();
    run_op(1'b0, 5'd0, 32'd9, 32'd9, 4, 1'b0, 32'd81);
    run_op(1'b1, 5'd0, 32'd9, 32'd0, 4, 1'b1, 32'd0);
    run_op(1'b1, 5'd1, 32'hDEAD_BEEF, 32'd1, 5, 1'b0, 32'hDEAD_BEEF);
    settle();
    chk("rd0 wb beats", 32'(wb_beats), 2);
    idle(4);

    // reset during BUSY
    run_op(1'b0, 5'd8, 32'd1, 32'd1, 6, 1'b0, 32'd1);
    idle(1);
    settle(); chk_en = 1'b0;
    @(posedge clock); #1;
    ex_isMult = 1'b1; ex_isDiv = 1'b0; ex_rd = 5'd8; md_resultRDY = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre-reset stall", 32'(stall), 1);
    chk("pre-reset busy_rd", 32'(busy_rd), 8);
    reset = 1'b1;
    #1;
    chk("reset mid-op stall", 32'(stall), 0);
    chk("reset mid-op busy_rd", 32'(busy_rd), 0);
    chk("reset mid-op ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    @(posedge clock); #1;
    reset = 1'b0; ex_isMult = 1'b0;
    settle(); clear_tallies();
    chk_en = 1'b1;
    idle(45);
    settle();
    chk("post-reset wb beats", 32'(wb_beats), 0);
    chk("post-reset stall cycles", 32'(stall_cyc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
